// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: sequencer/arbiter for the 2-bit branch-predictor counter table.
// One single-port RAM is shared between fetch lookups and resolved-branch updates.
// Updates are queued and applied as read-modify-write; reset/flush clears the table
// with a one-entry-per-cycle sweep.
module bp_table_ctrl #(
  parameter int unsigned IDX_BITS   = 10,
  parameter int unsigned UPD_DEPTH  = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [1:0]  INIT_VAL   = 2'b00
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                flush,
  input  logic                lk_valid,
  input  logic [31:0]         lk_pc,
  output logic                lk_ready,
  output logic                pred_valid,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  output logic                upd_ready,
  output logic                init_done,
  output logic                tbl_en,
  output logic                tbl_we,
  output logic [IDX_BITS-1:0] tbl_addr,
  output logic [1:0]          tbl_wdata,
  input  logic [1:0]          tbl_rdata
);

  localparam int unsigned PW = $clog2(UPD_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(UPD_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  state_t              state;
  logic                armed;
  logic [IDX_BITS-1:0] sweep_ptr;

  logic [IDX_BITS-1:0] fifo_idx   [UPD_DEPTH];
  logic                fifo_taken [UPD_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [SW-1:0]       starve;

  logic [IDX_BITS-1:0] rmw_idx;
  logic                rmw_taken;
  logic [1:0]          rmw_val;
  logic [1:0]          rmw_next;
  logic                pred_q;

  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic                fifo_full;
  logic                fifo_empty;
  logic                forced;
  logic                lk_take;
  logic                pop;
  logic                push;
  logic                unused_pc_bits;

  assign lk_idx  = lk_pc[IDX_BITS+1:2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{lk_pc[31:IDX_BITS+2], lk_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  // Drain is only ever forced with something queued, so the pop below is always legal.
  assign forced     = !fifo_empty && (fifo_full || (starve == STARVE_LIM));

  assign lk_ready   = (state == S_IDLE) && !forced;
  assign upd_ready  = !fifo_full && (state != S_INIT) && !flush;
  assign lk_take    = lk_valid && lk_ready;
  assign pop        = (state == S_IDLE) && !lk_take && !fifo_empty;
  assign push       = upd_valid && upd_ready;

  assign pred_valid = pred_q;
  assign pred_taken = pred_q & tbl_rdata[1];

  // Saturating 2-bit counter step applied to the value read during RMW_RD.
  always_comb begin
    rmw_next = tbl_rdata;
    if (rmw_taken) begin
      if (tbl_rdata != 2'b11) rmw_next = tbl_rdata + 2'b01;
    end else begin
      if (tbl_rdata != 2'b00) rmw_next = tbl_rdata - 2'b01;
    end
  end

  // Table port mux: sweep write, lookup/update read, or RMW write-back.
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    unique case (state)
      S_INIT: begin
        if (armed) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = sweep_ptr;
          tbl_wdata = INIT_VAL;
        end
      end
      S_IDLE: begin
        if (pop) begin
          tbl_en   = 1'b1;
          tbl_addr = fifo_idx[rd_ptr];
        end else if (lk_take) begin
          tbl_en   = 1'b1;
          tbl_addr = lk_idx;
        end
      end
      S_RMW_RD: begin
      end
      S_RMW_WR: begin
        // A flush in the write-back cycle aborts the update.
        if (!flush) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = rmw_idx;
          tbl_wdata = rmw_val;
        end
      end
      default: begin
      end
    endcase
  end

  // Update FIFO storage (contents need no reset; count/pointers define validity).
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= upd_idx;
      fifo_taken[wr_ptr] <= upd_taken;
    end
  end

  // Sequencer FSM, FIFO pointers, starvation counter and prediction-valid register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_INIT;
      armed     <= 1'b0;
      sweep_ptr <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      starve    <= '0;
      rmw_idx   <= '0;
      rmw_taken <= 1'b0;
      rmw_val   <= '0;
      pred_q    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      // A lookup accepted in the flush cycle still returns its prediction.
      pred_q <= lk_take;
      if (flush) begin
        state     <= S_INIT;
        sweep_ptr <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        starve    <= '0;
        init_done <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: begin
          end
        endcase

        unique case (state)
          S_INIT: begin
            // First cycle out of reset only arms the sweep so the port stays quiet under reset.
            if (!armed) begin
              armed <= 1'b1;
            end else begin
              sweep_ptr <= sweep_ptr + 1'b1;
              if (sweep_ptr == '1) begin
                state     <= S_IDLE;
                init_done <= 1'b1;
              end
            end
          end
          S_IDLE: begin
            if (pop) begin
              rmw_idx   <= fifo_idx[rd_ptr];
              rmw_taken <= fifo_taken[rd_ptr];
              state     <= S_RMW_RD;
            end else if (lk_take && !fifo_empty) begin
              starve <= starve + 1'b1;
            end
          end
          S_RMW_RD: begin
            rmw_val <= rmw_next;
            state   <= S_RMW_WR;
          end
          S_RMW_WR: begin
            starve <= '0;
            state  <= S_IDLE;
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// tb_bp_table_ctrl: directed plus randomized bench for bp_table_ctrl with a
// cycle-level reference of the arbitration rules and a counter-table scoreboard.
module tb_bp_table_ctrl;

  localparam int DEPTH  = 1024;
  localparam int UPD    = 4;
  localparam int STARVE = 8;

  logic        CLK;
  logic        RESET;
  logic        flush;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        init_done;
  logic        tbl_en;
  logic        tbl_we;
  logic [9:0]  tbl_addr;
  logic [1:0]  tbl_wdata;
  logic [1:0]  tbl_rdata;

  bp_table_ctrl #(
    .IDX_BITS   (10),
    .UPD_DEPTH  (4),
    .STARVE_MAX (8),
    .INIT_VAL   (2'b00)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .flush      (flush),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .lk_ready   (lk_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .init_done  (init_done),
    .tbl_en     (tbl_en),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .tbl_rdata  (tbl_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port table RAM, read data one cycle after enable.
  logic [1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int idx;
    bit taken;
  } upd_t;

  int   ncmp;
  int   nfail;
  bit   in_sweep;
  int   sweep_exp;
  upd_t q[$];
  upd_t infl;
  int   phase;
  int   starve;
  int   refc [DEPTH];
  bit   lk_acc_seen;
  bit   upd_acc_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int sat_upd(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    else   return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic logic [31:0] rpc();
    return ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic model_reset();
    q.delete();
    phase     = 0;
    starve    = 0;
    in_sweep  = 1;
    sweep_exp = 0;
    foreach (refc[i]) refc[i] = 0;
  endtask

  // One clock cycle: inputs are already driven; check this cycle, advance the edge, check registered results.
  task automatic cyc();
    int   sz;
    int   li;
    int   nv;
    bit   exp_ur;
    bit   forced;
    bit   fl;
    bit   pp;
    bit   pe;
    upd_t e;
    #1;
    pp = 0;
    pe = 0;
    fl = flush;
    sz = q.size();
    li = idx_of(lk_pc);
    exp_ur = !in_sweep && (sz < UPD) && !fl;
    chk("upd_ready", upd_ready, exp_ur);
    lk_acc_seen  = lk_valid && lk_ready;
    upd_acc_seen = upd_valid && upd_ready;
    if (in_sweep) begin
      chk("sweep_lk_ready", lk_ready, 0);
      chk("sweep_init_done", init_done, 0);
      if (tbl_en || sweep_exp != 0) begin
        chk("sweep_en", tbl_en, 1);
        chk("sweep_we", tbl_we, 1);
        chk("sweep_addr", tbl_addr, sweep_exp);
        chk("sweep_wdata", tbl_wdata, 0);
        sweep_exp++;
        if (sweep_exp == DEPTH) in_sweep = 0;
      end
    end else begin
      chk("init_done", init_done, 1);
      if (phase == 1) begin
        chk("rmw_rd_lk_ready", lk_ready, 0);
        chk("rmw_rd_port_idle", tbl_en, 0);
        phase = 2;
      end else if (phase == 2) begin
        chk("rmw_wr_lk_ready", lk_ready, 0);
        if (fl) begin
          chk("flush_no_write", tbl_en && tbl_we, 0);
        end else begin
          nv = sat_upd(refc[infl.idx], infl.taken);
          chk("rmw_wr_en", tbl_en, 1);
          chk("rmw_wr_we", tbl_we, 1);
          chk("rmw_wr_addr", tbl_addr, infl.idx);
          chk("rmw_wr_data", tbl_wdata, nv);
          refc[infl.idx] = nv;
          starve = 0;
        end
        phase = 0;
      end else begin
        forced = (sz > 0) && ((sz == UPD) || (starve == STARVE));
        chk("idle_lk_ready", lk_ready, !forced);
        if (fl) begin
          chk("flush_idle_no_write", tbl_en && tbl_we, 0);
        end else if (forced || (!lk_valid && sz > 0)) begin
          chk("upd_rd_en", tbl_en, 1);
          chk("upd_rd_we", tbl_we, 0);
          chk("upd_rd_addr", tbl_addr, q[0].idx);
          infl  = q.pop_front();
          phase = 1;
        end else if (lk_valid) begin
          chk("lk_rd_en", tbl_en, 1);
          chk("lk_rd_we", tbl_we, 0);
          chk("lk_rd_addr", tbl_addr, li);
          pp = 1;
          pe = (refc[li] >= 2);
          if (sz > 0) starve++;
        end else begin
          chk("idle_port_quiet", tbl_en, 0);
        end
      end
    end
    if (upd_valid && exp_ur) begin
      e.idx   = idx_of(upd_pc);
      e.taken = upd_taken;
      q.push_back(e);
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("pred_valid", pred_valid, pp);
    if (pp) chk("pred_taken", pred_taken, pe);
    if (fl) model_reset();
  endtask

  task automatic run_sweep();
    for (int k = 0; k < 1100 && in_sweep; k++) cyc();
    chk("sweep_complete", in_sweep, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q.size() > 0 || phase != 0); k++) cyc();
    chk("drain_complete", q.size() + phase, 0);
  endtask

  task automatic quiet_inputs();
    flush     = 0;
    lk_valid  = 0;
    upd_valid = 0;
    upd_taken = 0;
  endtask

  initial begin
    int n;
    int m;
    int p;
    ncmp  = 0;
    nfail = 0;
    RESET = 0;
    lk_pc  = '0;
    upd_pc = '0;
    quiet_inputs();
    model_reset();

    // Held in reset: every output low.
    repeat (3) @(negedge CLK);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_lk_ready", lk_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_init_done", init_done, 0);

    // Clear sweep after reset release, with requests pending that must be refused.
    RESET     = 1;
    lk_valid  = 1;
    lk_pc     = 32'h10;
    upd_valid = 1;
    upd_pc    = 32'h10;
    run_sweep();
    quiet_inputs();
    repeat (2) cyc();

    // Single lookup of idx 4 after init.
    lk_valid = 1;
    lk_pc    = 32'h0000_0010;
    cyc();
    lk_valid = 0;
    cyc();

    // Three taken updates back to back: idx 4 goes 0 -> 3.
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1;
      upd_pc    = 32'h10;
      upd_taken = 1;
      cyc();
    end
    upd_valid = 0;
    drain();
    chk("idx4_after_3_taken", mem[4], 3);

    // Saturation at 3, then a not-taken step down to 2.
    upd_valid = 1; upd_taken = 1; cyc();
    upd_valid = 0; drain();
    chk("idx4_saturated", mem[4], 3);
    upd_valid = 1; upd_taken = 0; cyc();
    upd_valid = 0; drain();
    chk("idx4_after_not_taken", mem[4], 2);
    lk_valid = 1; lk_pc = 32'h10; cyc();
    lk_valid = 0; cyc();

    // Continuous lookups with one queued update: drain forced after STARVE lookups.
    lk_valid  = 1;
    lk_pc     = rpc();
    upd_valid = 1;
    upd_pc    = 32'h24;
    upd_taken = 1;
    cyc();
    upd_valid = 0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      lk_pc = rpc();
      cyc();
      if (!lk_acc_seen) break;
      n++;
    end
    chk("starve_lookups", n, STARVE);
    m = 1;
    for (int k = 0; k < 10; k++) begin
      lk_pc = rpc();
      cyc();
      if (lk_acc_seen) break;
      m++;
    end
    chk("forced_stall_cycles", m, 3);
    lk_valid = 0;
    drain();
    chk("idx9_updated", mem[9], 1);

    // Fill the FIFO under continuous lookups.
    lk_valid  = 1;
    upd_valid = 1;
    p = 0;
    for (int k = 0; k < 10; k++) begin
      lk_pc     = rpc();
      upd_pc    = rpc();
      upd_taken = 1'($urandom_range(0, 1));
      cyc();
      if (!upd_acc_seen) break;
      p++;
    end
    chk("fill_pushes", p, UPD);
    upd_valid = 0;
    for (int k = 0; k < 20; k++) begin
      lk_pc = rpc();
      cyc();
    end
    lk_valid = 0;
    drain();

    // Flush while an update sits in RMW_RD, with a concurrent update offered.
    upd_valid = 1; upd_pc = 32'h10; upd_taken = 1; cyc();
    upd_pc = 32'h14; cyc();
    flush  = 1; upd_pc = 32'h18; cyc();
    quiet_inputs();
    run_sweep();
    repeat (4) cyc();
    chk("idx4_cleared_by_flush", mem[4], 0);

    // Randomized traffic with one flush in the middle.
    for (int k = 0; k < 1500; k++) begin
      lk_valid  = ($urandom_range(0, 3) != 0);
      lk_pc     = rpc();
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_pc    = rpc();
      upd_taken = 1'($urandom_range(0, 1));
      flush     = (k == 700);
      if (flush) lk_valid = 0;
      cyc();
      if (in_sweep) begin
        quiet_inputs();
        run_sweep();
      end
    end
    quiet_inputs();
    drain();
    for (int i = 0; i < 8; i++) chk("final_counter", mem[i], refc[i]);

    // Asynchronous reset in the middle of traffic.
    lk_valid  = 1;
    lk_pc     = rpc();
    upd_valid = 1;
    upd_pc    = rpc();
    cyc();
    #2;
    RESET = 0;
    #1;
    chk("midrst_tbl_en", tbl_en, 0);
    chk("midrst_lk_ready", lk_ready, 0);
    chk("midrst_upd_ready", upd_ready, 0);
    chk("midrst_pred_valid", pred_valid, 0);
    chk("midrst_init_done", init_done, 0);
    @(negedge CLK);
    quiet_inputs();
    model_reset();
    RESET = 1;
    run_sweep();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
